// File: rtl/usb_tx_encoder_if.sv
// Byte-stream handshake and line-side signals of the USB full-speed transmit encoder.
// The byte source uses the master modport and the encoder uses the slave modport.
interface usb_tx_encoder_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, dplus_out, dminus_out, tx_active, tx_done, tx_err
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, dplus_out, dminus_out, tx_active, tx_done, tx_err
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB 1.1 full-speed transmitter: one-byte buffer, SYNC, LSB-first serializer,
// bit stuffing, NRZI and EOP, one line symbol per CLKS_PER_BIT clocks.
//
// state   | meaning
// IDLE    | line J, waiting for a buffered byte
// SYNC    | sending SYNC_BYTE
// DATA    | sending shifter bits, reloading from the buffer at byte ends
// EOP_SE0 | SE0 for two bit times
// EOP_J   | J for one bit time, then back to IDLE
module usb_tx_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
    input  logic            clk,
    input  logic            rst,
    usb_tx_encoder_if.slave tx
);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_EOP_SE0 = 3'd3;
    localparam logic [2:0] S_EOP_J   = 3'd4;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    logic [2:0]    state_q, state_d;
    logic          buf_full_q, buf_full_d;
    logic [7:0]    buf_data_q, buf_data_d;
    logic          buf_last_q, buf_last_d;
    logic [7:0]    shift_q, shift_d;
    logic          cur_last_q, cur_last_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    ones_q, ones_d;
    logic [1:0]    line_q, line_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic ready;
    logic accept;
    logic active;
    logic boundary;
    logic emit_en;
    logic emit_bit;
    logic load_en;
    logic eop_en;

    assign active   = (state_q != S_IDLE);
    assign boundary = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign ready    = !buf_full_q && (state_q != S_EOP_SE0) && (state_q != S_EOP_J);
    assign accept   = tx.tx_valid && ready;

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        shift_d    = shift_q;
        cur_last_d = cur_last_q;
        bit_idx_d  = bit_idx_q;
        ones_d     = ones_q;
        line_d     = line_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        emit_en    = 1'b0;
        emit_bit   = 1'b0;
        load_en    = 1'b0;
        eop_en     = 1'b0;

        timer_d = '0;
        if (active && !boundary) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    state_d   = S_SYNC;
                    bit_idx_d = '0;
                    emit_en   = 1'b1;
                    emit_bit  = SYNC_BYTE[0];
                end
            end
            S_SYNC: begin
                if (boundary) begin
                    if (ones_q == 3'd6) begin
                        emit_en = 1'b1;
                    end else if (bit_idx_q != 3'd7) begin
                        emit_en   = 1'b1;
                        emit_bit  = SYNC_BYTE[bit_idx_q + 3'd1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        load_en = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // A pending stuffed zero always wins, which defers the reload/EOP decision by one bit.
                if (boundary) begin
                    if (ones_q == 3'd6) begin
                        emit_en = 1'b1;
                    end else if (bit_idx_q != 3'd7) begin
                        emit_en   = 1'b1;
                        emit_bit  = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (cur_last_q) begin
                        eop_en = 1'b1;
                    end else if (buf_full_q) begin
                        load_en = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        eop_en = 1'b1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (boundary) begin
                    if (bit_idx_q == 3'd0) begin
                        bit_idx_d = 3'd1;
                    end else begin
                        state_d = S_EOP_J;
                        line_d  = LINE_J;
                    end
                end
            end
            S_EOP_J: begin
                if (boundary) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                line_d  = LINE_J;
            end
        endcase

        // The first data bit of a byte goes out on the same boundary as the load.
        if (load_en) begin
            shift_d    = {1'b0, buf_data_q[7:1]};
            cur_last_d = buf_last_q;
            buf_full_d = 1'b0;
            bit_idx_d  = '0;
            state_d    = S_DATA;
            emit_en    = 1'b1;
            emit_bit   = buf_data_q[0];
        end

        if (eop_en) begin
            state_d   = S_EOP_SE0;
            line_d    = LINE_SE0;
            ones_d    = '0;
            bit_idx_d = '0;
        end

        if (emit_en) begin
            if (emit_bit) begin
                ones_d = ones_q + 3'd1;
            end else begin
                line_d = (line_q == LINE_K) ? LINE_J : LINE_K;
                ones_d = '0;
            end
        end

        if (accept) begin
            buf_full_d = 1'b1;
            buf_data_d = tx.tx_data;
            buf_last_d = tx.tx_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            buf_last_q <= 1'b0;
            shift_q    <= '0;
            cur_last_q <= 1'b0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            ones_q     <= '0;
            line_q     <= LINE_J;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            shift_q    <= shift_d;
            cur_last_q <= cur_last_d;
            bit_idx_q  <= bit_idx_d;
            timer_q    <= timer_d;
            ones_q     <= ones_d;
            line_q     <= line_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx.tx_ready   = ready;
    assign tx.dplus_out  = line_q[1];
    assign tx.dminus_out = line_q[0];
    assign tx.tx_active  = active;
    assign tx.tx_done    = done_q;
    assign tx.tx_err     = err_q;

endmodule
